// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier: one shared 2*WIDTH-bit adder stepped over the multiplier bits.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [2*WIDTH-1:0]     a_sh;
    logic [2*WIDTH-1:0]     acc;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]       b_sh;
    logic [CW-1:0]          cnt;
    logic                   last;

    // product is loaded from acc_next so it is already valid in the done cycle
    always_comb begin
        acc_next = acc;
        if (b_sh[0]) begin
            acc_next = acc + a_sh;
        end
    end

    always_comb begin
        last = (cnt == CW'(WIDTH - 1));
`ifdef EARLY_TERM_EN
        if (b_sh[WIDTH-1:1] == '0) begin
            last = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= {{WIDTH{1'b0}}, a};
                        b_sh  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
